// File: rtl/sasa_data_pkg.sv
// sasa_data_pkg
//   Shared types and constants for the SASA data server.
//   - sasa_ds_state_t : EMPTY (accepting load words) / READY (serving requests)
//   - SASA_Q_MAX/MIN  : CAM1 match range used when saturation is enabled
//   - default matrix geometry, consistent with SASA_Seq_len / SASA_Seq_shift
package sasa_data_pkg;

  localparam int unsigned SASA_SEQ_LEN_DEF   = 16;
  localparam int unsigned SASA_SEQ_SHIFT_DEF = 4;

  localparam int unsigned SASA_DATA_W_DEF   = 32;
  localparam int unsigned SASA_IN_FRAC_DEF  = 16;
  localparam int unsigned SASA_OUT_FRAC_DEF = 4;

  localparam int SASA_Q_MAX = 128;
  localparam int SASA_Q_MIN = -127;

  typedef enum logic {
    ST_EMPTY,
    ST_READY
  } sasa_ds_state_t;

endpackage

// File: rtl/sasa_quant.sv
// sasa_quant
//   Combinational requantizer: signed fixed point with IN_FRAC fractional
//   bits -> signed fixed point with OUT_FRAC fractional bits, rounded half
//   away from zero. Intermediate sums are DATA_W+1 bits wide so the most
//   negative input and the largest positive input cannot overflow.
//   Optional macro SASA_DATA_SAT_EN: clip the result to [SASA_Q_MIN, SASA_Q_MAX].
// Ports
//   in_word  in  DATA_W  signed input value
//   q_word   out DATA_W  signed rounded (and optionally saturated) value
module sasa_quant
   import sasa_data_pkg::*;
#(
   parameter int unsigned DATA_W   = SASA_DATA_W_DEF,
   parameter int unsigned IN_FRAC  = SASA_IN_FRAC_DEF,
   parameter int unsigned OUT_FRAC = SASA_OUT_FRAC_DEF
) (
   input  logic [DATA_W-1:0] in_word,
   output logic [DATA_W-1:0] q_word
);

   localparam int unsigned SH = IN_FRAC - OUT_FRAC;
   localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(1) <<< (SH - 1);

   logic signed [DATA_W:0] in_ext;
   logic signed [DATA_W:0] mag;
   logic signed [DATA_W:0] sum;
   logic signed [DATA_W:0] rnd;
   logic signed [DATA_W:0] res;

   always_comb begin
      in_ext = {in_word[DATA_W-1], in_word};
      mag    = '0;
      sum    = '0;
      rnd    = '0;
      // Negative inputs are rounded on their magnitude so that ties move
      // away from zero symmetrically.
      if (!in_ext[DATA_W]) begin
         sum = in_ext + HALF;
         rnd = sum >>> SH;
      end else begin
         mag = -in_ext;
         sum = mag + HALF;
         rnd = -(sum >>> SH);
      end
`ifdef SASA_DATA_SAT_EN
      if (rnd > (DATA_W+1)'(SASA_Q_MAX))
         res = (DATA_W+1)'(SASA_Q_MAX);
      else if (rnd < (DATA_W+1)'(SASA_Q_MIN))
         res = (DATA_W+1)'(SASA_Q_MIN);
      else
         res = rnd;
`else
      res = rnd;
`endif
      q_word = res[DATA_W-1:0];
   end

endmodule

// File: rtl/sasa_data_server.sv
// sasa_data_server
//   Responder for the SASA data-request interface. Holds one SEQ_LEN x SEQ_LEN
//   score matrix, loaded row-major (y outer, x inner) as Q16.16 words and
//   quantized to Q.4 at load time; answers data_req with a 1-cycle registered
//   read of mem[y*SEQ_LEN + x].
//   Optional macro SASA_DATA_SAT_EN: saturate stored scores to [-127, 128].
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   clear             sync pulse: drop the matrix, return to EMPTY
//   load_valid/ready  load handshake (ready only while EMPTY)
//   load_data         signed Q16.16 score
//   full              matrix complete, requests are served
//   data_req          read request, addressed by data_addr_x / data_addr_y
//   data, data_valid  registered response, valid the cycle after a request
//   req_err           pulse one cycle after a request made while not full
//   req_cnt           served request count, wrapping
module sasa_data_server
   import sasa_data_pkg::*;
#(
   parameter int unsigned SEQ_LEN   = SASA_SEQ_LEN_DEF,
   parameter int unsigned SEQ_SHIFT = SASA_SEQ_SHIFT_DEF,
   parameter int unsigned DATA_W    = SASA_DATA_W_DEF,
   parameter int unsigned IN_FRAC   = SASA_IN_FRAC_DEF,
   parameter int unsigned OUT_FRAC  = SASA_OUT_FRAC_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [DATA_W-1:0]    load_data,
   output logic                 full,
   input  logic                 data_req,
   input  logic [SEQ_SHIFT-1:0] data_addr_x,
   input  logic [SEQ_SHIFT-1:0] data_addr_y,
   output logic [DATA_W-1:0]    data,
   output logic                 data_valid,
   output logic                 req_err,
   output logic [15:0]          req_cnt
);

   localparam int unsigned AW    = 2 * SEQ_SHIFT;
   localparam int unsigned DEPTH = SEQ_LEN * SEQ_LEN;
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   sasa_ds_state_t state, state_nxt;

   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_addr;
   logic [DATA_W-1:0] q_word;
   logic              wr_en;
   logic              rd_en;
   logic              req_bad;

   logic [DATA_W-1:0] mem [DEPTH];

   sasa_quant #(
      .DATA_W   (DATA_W),
      .IN_FRAC  (IN_FRAC),
      .OUT_FRAC (OUT_FRAC)
   ) u_quant (
      .in_word (load_data),
      .q_word  (q_word)
   );

   assign rd_addr = {data_addr_y, data_addr_x};

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_EMPTY;
      else
         state <= state_nxt;
   end

   // clear has priority over both a load transfer and a request.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      full       = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      req_bad    = 1'b0;
      case (state)
         ST_EMPTY: begin
            load_ready = 1'b1;
            if (!clear) begin
               req_bad = data_req;
               if (load_valid) begin
                  wr_en = 1'b1;
                  if (wr_ptr == LAST)
                     state_nxt = ST_READY;
               end
            end
         end
         ST_READY: begin
            full = 1'b1;
            if (clear)
               state_nxt = ST_EMPTY;
            else
               rd_en = data_req;
         end
         default: state_nxt = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         data       <= '0;
         data_valid <= 1'b0;
         req_err    <= 1'b0;
         req_cnt    <= '0;
      end else begin
         data_valid <= rd_en;
         req_err    <= req_bad;
         if (clear)
            wr_ptr <= '0;
         else if (wr_en)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         if (rd_en) begin
            data    <= mem[rd_addr];
            req_cnt <= req_cnt + 16'd1;
         end
      end
   end

   // Storage is not reset; a new matrix always overwrites every entry
   // before READY is reached.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= q_word;
   end

endmodule

// File: doc/sasa_data_server.md
# sasa_data_server

Synthesizable responder for the SASA data-request interface. It holds one SEQ_LEN×SEQ_LEN attention-score matrix, loaded row-major through a valid/ready port in Q16.16. Each score is quantized once, at load time, to the SASA Q.4 integer format (×16, rounded half away from zero). It answers SASA `data_req`/`data_addr_x`/`data_addr_y` requests with the stored word. This replaces the behavioural feeder for FPGA and gate-level runs.

## Interface
- SEQ_LEN, 16, matrix dimension (equals SASA_Seq_len)
- SEQ_SHIFT, 4, log2(SEQ_LEN), width of each address
- DATA_W, 32, width of the load and response words
- IN_FRAC, 16, fractional bits of `load_data`
- OUT_FRAC, 4, fractional bits of `data`
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- clear  in  1  sync pulse: discard matrix and return to EMPTY
- load_valid  in  1  `load_data` valid
- load_ready  out  1  block accepts a load word
- load_data  in  DATA_W  signed Q16.16 score, row-major (y outer, x inner)
- full  out  1  matrix complete, requests are served
- data_req  in  1  SASA read request
- data_addr_x  in  SEQ_SHIFT  column
- data_addr_y  in  SEQ_SHIFT  row
- data  out  DATA_W  signed quantized score
- data_valid  out  1  `data` holds a response
- req_err  out  1  one-cycle pulse: request arrived while not full
- req_cnt  out  16  number of served requests, wraps

## Operation
- States: EMPTY and READY (enum `sasa_ds_state_t`).
- **EMPTY**
  - `load_ready` = 1.
  - A transfer occurs when `load_valid && load_ready`.
  - Each transfer stores quant(`load_data`) at `mem[wr_ptr]` and increments `wr_ptr` (8 bits for SEQ_LEN 16).
  - The transfer with `wr_ptr == SEQ_LEN*SEQ_LEN-1` moves the block to READY and sets `wr_ptr` to 0.
- **READY**
  - `load_ready` = 0 and `full` = 1.
  - `load_valid` is ignored.
  - `data_req` reads `mem[data_addr_y*SEQ_LEN + data_addr_x]`.
  - `data_req` may stay high on back-to-back cycles with changing addresses. Every cycle produces one response.
- **Request in EMPTY:** `req_err` pulses, `data_valid` stays 0, `data` holds its previous value.
- **clear:** returns the block to EMPTY with `wr_ptr` = 0 and `full` = 0. `mem` contents are not cleared.
- **Simultaneous events:**
  - `clear` with `load_valid`: clear wins, no write.
  - `clear` with `data_req`: clear wins, no response, no `req_err`.
- **Quantization**, with h = 2^(IN_FRAC-OUT_FRAC-1):
  - in ≥ 0: q = (in + h) >>> (IN_FRAC-OUT_FRAC).
  - in < 0: q = −((−in + h) >> (IN_FRAC-OUT_FRAC)).
  - Intermediate sums use DATA_W+1 bits.
- **Counter:** `req_cnt` increments on each served request and wraps from 0xFFFF to 0.

## Timing
- Reset values:
  - state EMPTY, so `load_ready` = 1; loads are ignored while `reset` is high.
  - `full` = 0, `data` = 0, `data_valid` = 0, `req_err` = 0, `req_cnt` = 0, `wr_ptr` = 0.
- Load: one word per cycle at full throughput.
- `load_ready` and `full` are registered state decodes. The transition to READY is visible the cycle after the last transfer.
- Read latency is 1 cycle. A request at edge N gives `data`/`data_valid` valid after edge N+1, i.e. sampled by SASA at edge N+1.
- `data_valid` is high for exactly the cycles following request cycles.
- `req_err` is registered, 1 cycle after the offending request.
- Reset asserted mid-load or mid-read: all outputs return to reset values immediately. A partial matrix is abandoned.

## Configuration
- `SASA_DATA_SAT_EN` defined: the quantized value is saturated to the CAM1 match range [−127, 128] before storage.
- Undefined: the quantized value is stored unclipped in full DATA_W two's complement.

## Structure
- Package `sasa_data_pkg` holds:
  - `sasa_ds_state_t`
  - CAM range constants `SASA_Q_MAX` = 128 and `SASA_Q_MIN` = −127
  - default SEQ_LEN, SEQ_SHIFT and fraction widths, kept consistent with the `SASA_Seq_len`/`SASA_Seq_shift` defines
- One sub-module, `sasa_quant`: combinational rounding plus the optional saturation, parameterized by IN_FRAC/OUT_FRAC.
- Storage is a single SEQ_LEN² × DATA_W array with a registered read.

## Test plan
- Load 256 words, word k = k·0x1000 (k/16.0) → `full` rises the cycle after word 255. Request (x=3, y=2) → `data` = 35 one cycle later. `req_cnt` = 1.
- Quantize 0x00018000 (1.5) → 24; 0x00000800 (+1/32) → 1; 0xFFFFF800 (−1/32) → −1; 0xFFFFF000 (−1/16) → −1.
- With `SASA_DATA_SAT_EN`: 10.0 → 128, −9.0 → −127. Without it: 10.0 → 160, −9.0 → −144.
- Request after 100 loads → `req_err` pulses, `data_valid` = 0. Hold `load_valid` in READY → no write: `mem[0]` unchanged on read-back.
- Back-to-back requests over all 256 addresses (x fastest) → 256 consecutive `data_valid` cycles in row-major order.
- `clear` together with `data_req` in READY → no `data_valid`, `full` = 0 and `load_ready` = 1 next cycle. Assert `reset` at load word 50 → `wr_ptr` = 0, and a reload of 256 words succeeds.
